dft4_power_peak: RTL and testbench

- Downstream consumer of the 4-point DFT stage.
- Captures one frame of 4 complex bins (real/imag pairs) and computes power |X[k]|^2 = Xr^2 + Xi^2 per bin, one bin per cycle on a single shared squarer pair.
- Streams the bin powers out over a valid/ready interface.
- Reports the peak-power bin for the frame to the detection logic that follows.

---
 rtl/dft_pkg.sv | 17 +
 rtl/dft4_power_peak_if.sv | 32 +++
 rtl/dft_bin_power.sv | 22 ++
 rtl/dft4_power_peak.sv | 127 ++++++++++++
 tb/tb_dft4_power_peak.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/dft_pkg.sv
// Shared types for the 4-point DFT bin-power / peak block.
package dft_pkg;

    localparam int DFT_N  = 4;
    localparam int DFT_DW = 16;
    localparam int DFT_PW = 2 * DFT_DW;

    typedef logic [1:0]        bin_t;
    typedef logic [DFT_PW-1:0] pwr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/dft4_power_peak_if.sv
// Frame input, power stream and peak report bundle for dft4_power_peak.
interface dft4_power_peak_if #(
    parameter int DW = dft_pkg::DFT_DW,
    parameter int PW = 2 * DW
);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xr0, xr1, xr2, xr3;
    logic signed [DW-1:0] xi0, xi1, xi2, xi3;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_bin;
    logic [PW-1:0]        out_pwr;
    logic                 out_last;
    logic                 peak_valid;
    logic [1:0]           peak_bin;
    logic [PW-1:0]        peak_pwr;

    modport slave (
        input  in_valid, xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3, out_ready,
        output in_ready, out_valid, out_bin, out_pwr, out_last,
        output peak_valid, peak_bin, peak_pwr
    );

    modport master (
        output in_valid, xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3, out_ready,
        input  in_ready, out_valid, out_bin, out_pwr, out_last,
        input  peak_valid, peak_bin, peak_pwr
    );

endinterface

// File: rtl/dft_bin_power.sv
// Combinational |X|^2 = Xr^2 + Xi^2 for one complex bin.
module dft_bin_power #(
    parameter int DW = 16,
    parameter int PW = 2 * DW
) (
    input  logic signed [DW-1:0] i_xr,
    input  logic signed [DW-1:0] i_xi,
    output logic [PW-1:0]        o_pwr
);

    logic signed [2*DW-1:0] w_xr, w_xi;
    logic signed [2*DW-1:0] w_rr, w_ii;

    assign w_xr = (2*DW)'(i_xr);
    assign w_xi = (2*DW)'(i_xi);
    assign w_rr = w_xr * w_xr;
    assign w_ii = w_xi * w_xi;

    // Each square is non-negative; only the sum can reach 2^(2DW-1).
    assign o_pwr = PW'($unsigned(w_rr)) + PW'($unsigned(w_ii));

endmodule

// File: rtl/dft4_power_peak.sv
// Bin power streamer and peak finder; DFT4_PWR_DC_SKIP_EN drops bin 0 from the peak search.
module dft4_power_peak
    import dft_pkg::*;
#(
    parameter int DW = DFT_DW,
    parameter int PW = 2 * DW
) (
    input logic             clk,
    input logic             reset,
    dft4_power_peak_if.slave bus
);

`ifdef DFT4_PWR_DC_SKIP_EN
    localparam bin_t SEED = 2'd1;
`else
    localparam bin_t SEED = 2'd0;
`endif

    state_t               r_state, w_next;
    bin_t                 r_cnt;
    logic signed [DW-1:0] r_xr [DFT_N];
    logic signed [DW-1:0] r_xi [DFT_N];
    logic signed [DW-1:0] w_xr [DFT_N];
    logic signed [DW-1:0] w_xi [DFT_N];
    logic [PW-1:0]        r_pwr [DFT_N];
    logic [PW-1:0]        w_pwr;
    logic [PW-1:0]        r_peak_pwr;
    bin_t                 r_peak_bin;
    logic                 r_peak_valid;
    logic                 w_peak_upd;

    assign w_xr[0] = bus.xr0;
    assign w_xr[1] = bus.xr1;
    assign w_xr[2] = bus.xr2;
    assign w_xr[3] = bus.xr3;
    assign w_xi[0] = bus.xi0;
    assign w_xi[1] = bus.xi1;
    assign w_xi[2] = bus.xi2;
    assign w_xi[3] = bus.xi3;

    dft_bin_power #(
        .DW (DW),
        .PW (PW)
    ) u_pwr (
        .i_xr  (r_xr[r_cnt]),
        .i_xi  (r_xi[r_cnt]),
        .o_pwr (w_pwr)
    );

    // Strict compare keeps the lowest index on ties.
    assign w_peak_upd = (r_cnt == SEED) ||
                        ((r_cnt > SEED) && (w_pwr > r_peak_pwr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid) w_next = CALC;
            CALC:    if (r_cnt == 2'd3) w_next = OUT;
            OUT:     if (bus.out_ready && r_cnt == 2'd3) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        unique case (r_state)
            IDLE: bus.in_ready = 1'b1;
            OUT: begin
                bus.out_valid = 1'b1;
                bus.out_last  = (r_cnt == 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_peak_bin   <= '0;
            r_peak_pwr   <= '0;
            r_peak_valid <= 1'b0;
            for (int i = 0; i < DFT_N; i++) begin
                r_xr[i]  <= '0;
                r_xi[i]  <= '0;
                r_pwr[i] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_cnt        <= '0;
                    r_peak_bin   <= '0;
                    r_peak_pwr   <= '0;
                    r_peak_valid <= 1'b0;
                    for (int i = 0; i < DFT_N; i++) begin
                        r_xr[i] <= w_xr[i];
                        r_xi[i] <= w_xi[i];
                    end
                end
                CALC: begin
                    r_pwr[r_cnt] <= w_pwr;
                    r_cnt        <= r_cnt + 1'b1;
                    if (w_peak_upd) begin
                        r_peak_bin <= r_cnt;
                        r_peak_pwr <= w_pwr;
                    end
                    if (r_cnt == 2'd3) r_peak_valid <= 1'b1;
                end
                OUT: if (bus.out_ready) r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.out_bin    = r_cnt;
    assign bus.out_pwr    = r_pwr[r_cnt];
    assign bus.peak_valid = r_peak_valid;
    assign bus.peak_bin   = r_peak_bin;
    assign bus.peak_pwr   = r_peak_pwr;

endmodule

// File: tb/tb_dft4_power_peak.sv
// Directed vector bench for dft4_power_peak (honours DFT4_PWR_DC_SKIP_EN).
module tb_dft4_power_peak;

    typedef struct packed {
        logic [0:3][15:0] xr;
        logic [0:3][15:0] xi;
        logic [0:3][31:0] pw;
        logic [1:0]       pb;
        logic [31:0]      pp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic pv_exp = 1'b0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    dft4_power_peak_if #(.DW(16), .PW(32)) bus ();

    dft4_power_peak #(.DW(16), .PW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.xr0 = v.xr[0]; bus.xr1 = v.xr[1];
        bus.xr2 = v.xr[2]; bus.xr3 = v.xr[3];
        bus.xi0 = v.xi[0]; bus.xi1 = v.xi[1];
        bus.xi2 = v.xi[2]; bus.xi3 = v.xi[3];
    endtask

    task automatic run_frame(input vec_t v, input int sb, input int sn);
        int lat;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_peak_valid", bus.peak_valid, pv_exp);
        drive(v);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("calc_in_ready", bus.in_ready, 0);
        chk("capture_drops_peak_valid", bus.peak_valid, 0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("first_valid_latency", lat, 4);
        for (int j = 0; j < 4; j++) begin
            if (j == sb) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < sn; s++) begin
                    bus.in_valid = (s[0] == 1'b0);
                    @(negedge clk);
                    chk("stall_valid", bus.out_valid, 1);
                    chk("stall_bin", bus.out_bin, j);
                    chk("stall_pwr", bus.out_pwr, v.pw[j]);
                    chk("stall_in_ready", bus.in_ready, 0);
                end
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            chk("beat_valid", bus.out_valid, 1);
            chk("beat_bin", bus.out_bin, j);
            chk("beat_pwr", bus.out_pwr, v.pw[j]);
            chk("beat_last", bus.out_last, (j == 3));
            if (j == 0) begin
                chk("peak_valid", bus.peak_valid, 1);
                chk("peak_bin", bus.peak_bin, v.pb);
                chk("peak_pwr", bus.peak_pwr, v.pp);
            end
            @(negedge clk);
        end
        chk("end_valid_low", bus.out_valid, 0);
        chk("end_in_ready", bus.in_ready, 1);
        chk("end_peak_hold", bus.peak_valid, 1);
        chk("end_peak_bin", bus.peak_bin, v.pb);
        pv_exp = 1'b1;
    endtask

    initial begin
        vecs[0].xr = {16'd100, 16'd0, 16'd0, 16'd0};
        vecs[0].xi = '0;
        vecs[0].pw = {32'd10000, 32'd0, 32'd0, 32'd0};
        vecs[0].pb = 2'd0;
        vecs[0].pp = 32'd10000;

        vecs[1].xr = {16'd0, 16'd3, -16'sd3, 16'd0};
        vecs[1].xi = {16'd0, 16'd4, 16'd0, -16'sd5};
        vecs[1].pw = {32'd0, 32'd25, 32'd9, 32'd25};
        vecs[1].pb = 2'd1;
        vecs[1].pp = 32'd25;

        vecs[2].xr = {4{16'h8000}};
        vecs[2].xi = {4{16'h8000}};
        vecs[2].pw = {4{32'h8000_0000}};
        vecs[2].pp = 32'h8000_0000;

        vecs[3].xr = {16'd200, 16'd10, 16'd0, 16'd0};
        vecs[3].xi = '0;
        vecs[3].pw = {32'd40000, 32'd100, 32'd0, 32'd0};

        vecs[4].xr = {-16'sd7, 16'd12, 16'd0, 16'd32767};
        vecs[4].xi = {16'd24, -16'sd5, 16'd30, 16'h8000};
        vecs[4].pw = {32'd625, 32'd169, 32'd900, 32'h7FFF_0001};
        vecs[4].pb = 2'd3;
        vecs[4].pp = 32'h7FFF_0001;
`ifdef DFT4_PWR_DC_SKIP_EN
        vecs[0].pb = 2'd1;
        vecs[0].pp = 32'd0;
        vecs[2].pb = 2'd1;
        vecs[3].pb = 2'd1;
        vecs[3].pp = 32'd100;
`else
        vecs[2].pb = 2'd0;
        vecs[3].pb = 2'd0;
        vecs[3].pp = 32'd40000;
`endif

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive('0);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bin", bus.out_bin, 0);
        chk("rst_out_pwr", bus.out_pwr, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_peak_valid", bus.peak_valid, 0);
        chk("rst_peak_bin", bus.peak_bin, 0);
        chk("rst_peak_pwr", bus.peak_pwr, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(vecs[i], -1, 0);

        run_frame(vecs[0], 2, 3);

        @(negedge clk);
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
`ifndef DFT4_PWR_DC_SKIP_EN
        chk("mid_calc_peak_pwr", bus.peak_pwr, 32'd10000);
`endif
        reset = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_pwr", bus.out_pwr, 0);
        chk("abort_peak_valid", bus.peak_valid, 0);
        chk("abort_peak_bin", bus.peak_bin, 0);
        chk("abort_peak_pwr", bus.peak_pwr, 0);
        reset = 1'b0;
        pv_exp = 1'b0;
        run_frame(vecs[4], -1, 0);
        run_frame(vecs[1], 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
